// File: rtl/axi_lite_sram.sv
`default_nettype none
// ============================================================================
// axi_lite_sram : AXI-Lite slave SRAM, one outstanding read and one write,
// programmable response latency. Optional macro AXI_SRAM_RAND_DELAY_EN.
// Revision : 1.0
// ============================================================================
module axi_lite_sram #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                RD_LAT      = 1,
  parameter int                WR_LAT      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_ar_valid_i,
  input  logic [ADDR_W-1:0] s_ar_addr_i,
  output logic              s_ar_ready_o,
  output logic              s_r_valid_o,
  output logic [DATA_W-1:0] s_r_data_o,
  output logic [1:0]        s_r_resp_o,
  input  logic              s_r_ready_i,
  input  logic              s_aw_valid_i,
  input  logic [ADDR_W-1:0] s_aw_addr_i,
  output logic              s_aw_ready_o,
  input  logic              s_w_valid_i,
  input  logic [DATA_W-1:0] s_w_data_i,
  input  logic [3:0]        s_w_strb_i,
  output logic              s_w_ready_o,
  output logic              s_b_valid_o,
  output logic [1:0]        s_b_resp_o,
  input  logic              s_b_ready_i
);

  localparam int                   C_IDX_W  = $clog2(DEPTH_WORDS);
  localparam int                   C_CNT_W  = 16;
  localparam logic [ADDR_W:0]      C_SPAN   = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [C_CNT_W-1:0]   C_ONE    = C_CNT_W'(1);
  localparam logic [1:0]           C_OKAY   = 2'b00;
  localparam logic [1:0]           C_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0, R_DELAY = 2'd1, R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_DELAY = 2'd1, W_RESP = 2'd2;

  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];
  logic [C_CNT_W-1:0] rd_delay, wr_delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign rd_delay = C_CNT_W'(lfsr_q[3:0]) + C_ONE;
  assign wr_delay = C_CNT_W'(lfsr_q[3:0]) + C_ONE;
`else
  assign rd_delay = C_CNT_W'(RD_LAT);
  assign wr_delay = C_CNT_W'(WR_LAT);
`endif

  // ---------------- read channel ----------------
  logic [1:0]         r_state_q, r_state_d;
  logic [C_CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [C_IDX_W-1:0] r_idx_q, r_idx_d;
  logic               r_ok_q, r_ok_d;
  logic               r_enter_resp;
  logic [DATA_W-1:0]  r_data_q;
  logic [1:0]         r_resp_q;
  logic [ADDR_W-1:0]  ar_off;
  logic               ar_ok;

  assign ar_off = s_ar_addr_i - BASE_ADDR;
  assign ar_ok  = (s_ar_addr_i >= BASE_ADDR) && ({1'b0, ar_off} < C_SPAN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_ok_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_ok_q    <= r_ok_d;
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    r_cnt_d      = r_cnt_q;
    r_idx_d      = r_idx_q;
    r_ok_d       = r_ok_q;
    r_enter_resp = 1'b0;
    case (r_state_q)
      R_IDLE: if (s_ar_valid_i) begin
        r_idx_d = ar_off[C_IDX_W+1:2];
        r_ok_d  = ar_ok;
        if (rd_delay <= C_ONE) begin
          r_state_d    = R_RESP;
          r_enter_resp = 1'b1;
        end else begin
          r_state_d = R_DELAY;
          r_cnt_d   = rd_delay - C_ONE;
        end
      end
      R_DELAY: if (r_cnt_q == C_ONE) begin
        r_state_d    = R_RESP;
        r_enter_resp = 1'b1;
        r_cnt_d      = '0;
      end else begin
        r_cnt_d = r_cnt_q - C_ONE;
      end
      R_RESP:  if (s_r_ready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_ar_ready_o = (r_state_q == R_IDLE);
    s_r_valid_o  = (r_state_q == R_RESP);
  end

  // Read data is captured once on entry to R_RESP and held until the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_q <= '0;
      r_resp_q <= C_OKAY;
    end else if (r_enter_resp) begin
      r_data_q <= r_ok_d ? mem_q[r_idx_d] : '0;
      r_resp_q <= r_ok_d ? C_OKAY : C_SLVERR;
    end
  end

  assign s_r_data_o = r_data_q;
  assign s_r_resp_o = r_resp_q;

  // ---------------- write channel ----------------
  logic [1:0]         w_state_q, w_state_d;
  logic [C_CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic               aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0]  aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic [3:0]         w_strb_q, w_strb_d;
  logic               w_commit;
  logic [1:0]         b_resp_q;
  logic [ADDR_W-1:0]  aw_off;
  logic               aw_ok;

  assign aw_off = aw_addr_d - BASE_ADDR;
  assign aw_ok  = (aw_addr_d >= BASE_ADDR) && ({1'b0, aw_off} < C_SPAN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  // The _d copies of address/data/strobe are what the commit uses, so a
  // handshake on the same edge as the commit decision is seen directly.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_commit  = 1'b0;
    if (s_aw_valid_i && s_aw_ready_o) begin
      aw_got_d  = 1'b1;
      aw_addr_d = s_aw_addr_i;
    end
    if (s_w_valid_i && s_w_ready_o) begin
      w_got_d  = 1'b1;
      w_data_d = s_w_data_i;
      w_strb_d = s_w_strb_i;
    end
    case (w_state_q)
      W_IDLE: if (aw_got_d && w_got_d) begin
        if (wr_delay <= C_ONE) begin
          w_state_d = W_RESP;
          w_commit  = 1'b1;
        end else begin
          w_state_d = W_DELAY;
          w_cnt_d   = wr_delay - C_ONE;
        end
      end
      W_DELAY: if (w_cnt_q == C_ONE) begin
        w_state_d = W_RESP;
        w_commit  = 1'b1;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = w_cnt_q - C_ONE;
      end
      W_RESP: if (s_b_ready_i) begin
        w_state_d = W_IDLE;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_aw_ready_o = (w_state_q == W_IDLE) && !aw_got_q;
    s_w_ready_o  = (w_state_q == W_IDLE) && !w_got_q;
    s_b_valid_o  = (w_state_q == W_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         b_resp_q <= C_OKAY;
    else if (w_commit) b_resp_q <= aw_ok ? C_OKAY : C_SLVERR;
  end

  assign s_b_resp_o = b_resp_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_commit && aw_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_d[b]) mem_q[aw_off[C_IDX_W+1:2]][8*b +: 8] <= w_data_d[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_sram.md
# axi_lite_sram

AXI-Lite slave memory that the instruction fetch unit (and later the LSU) issues its AR/R and AW/W/B transactions to. It holds a word-addressed SRAM mapped at a fixed base address and answers each request after a programmable latency, one outstanding read and one outstanding write at a time. It is the bus target directly upstream of the fetch stage and supplies every instruction word the fetch stage latches.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; strobe is 4 bits)
- DEPTH_WORDS, 4096, memory depth in 32-bit words
- BASE_ADDR, 32'h8000_0000, first mapped byte address
- RD_LAT, 1, read latency in cycles from AR handshake to R valid (>=1)
- WR_LAT, 1, write latency in cycles from last of AW/W handshake to B valid (>=1)

Ports (clk/reset: one clock; reset is synchronous and active-high; clk_i and rst_i as elsewhere in the codebase):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_ar_valid_i  in  1  read address valid
- s_ar_addr_i  in  ADDR_W  read byte address
- s_ar_ready_o  out  1  read address ready
- s_r_valid_o  out  1  read data valid
- s_r_data_o  out  DATA_W  read data
- s_r_resp_o  out  2  read response (00 OKAY, 10 SLVERR)
- s_r_ready_i  in  1  read data ready
- s_aw_valid_i  in  1  write address valid
- s_aw_addr_i  in  ADDR_W  write byte address
- s_aw_ready_o  out  1  write address ready
- s_w_valid_i  in  1  write data valid
- s_w_data_i  in  DATA_W  write data
- s_w_strb_i  in  4  byte strobes
- s_w_ready_o  out  1  write data ready
- s_b_valid_o  out  1  write response valid
- s_b_resp_o  out  2  write response
- s_b_ready_i  in  1  write response ready

## Operation
- Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- Read FSM R_IDLE -> R_DELAY -> R_RESP -> R_IDLE. s_ar_ready_o = (state==R_IDLE). AR handshake latches address, loads delay counter; R_DELAY decrements, skipped when delay==1. Entering R_RESP samples memory into s_r_data_o. s_r_valid_o = (state==R_RESP); data/resp held stable until R handshake.
- Out-of-range read: s_r_resp_o=10, s_r_data_o=0, no memory access.
- Write FSM W_IDLE -> W_DELAY -> W_RESP -> W_IDLE. In W_IDLE, s_aw_ready_o high until AW accepted, s_w_ready_o high until W accepted; either order or same cycle. Once both latched, delay counts; commit on edge entering W_RESP, per-byte per s_w_strb_i. Out-of-range write: no commit, s_b_resp_o=10.
- Read and write FSMs independent. Same-word read entering R_RESP on the edge a write commits returns old data.
- Reset: FSMs to idle, counters cleared, latched AW/W flags cleared; memory contents not cleared.

## Timing
- Reset values: s_ar_ready_o=1, s_aw_ready_o=1, s_w_ready_o=1, s_r_valid_o=0, s_b_valid_o=0, s_r_data_o=0, s_r_resp_o=00, s_b_resp_o=00.
- AR handshake at edge T -> s_r_valid_o high from cycle T+RD_LAT; R handshake at edge U -> s_ar_ready_o high in cycle U+1. Back-to-back read period = RD_LAT+1 cycles minimum.
- Later of AW/W handshake at edge T -> s_b_valid_o from T+WR_LAT; ready lines return in cycle after B handshake.
- Valid outputs never deassert without handshake except on reset. Reset mid-transaction drops valid the cycle after rst_i is sampled high.

## Configuration
- AXI_SRAM_RAND_DELAY_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle); each AR/write load uses delay = 1 + lfsr[3:0] (1..16), ignoring RD_LAT/WR_LAT.
- Undefined: delays fixed at RD_LAT / WR_LAT; no LFSR logic.

## Test plan
- Reset then AR 32'h8000_0000 with word 0 = 32'h0000_0413, RD_LAT=1, r_ready=1 -> r_valid next cycle, data 32'h0000_0413, resp 00.
- r_ready held low 5 cycles after r_valid -> data/resp stable, ar_ready stays 0, completes on ready.
- AW 32'h8000_0004 one cycle before W 32'hDEAD_BEEF strb 4'b0011 over word 32'h1111_1111 -> B OKAY; readback 32'h1111_BEEF.
- AR 32'h7FFF_FFFC and AW 32'h8000_4000 (DEPTH_WORDS=4096) -> r_resp 10 data 0; b_resp 10, memory unchanged.
- rst_i asserted while in R_DELAY (RD_LAT=4) -> r_valid never asserts, ar_ready=1 next cycle, memory unchanged.
- AXI_SRAM_RAND_DELAY_EN: 100 reads -> every latency within 1..16, data correct, at least two distinct latencies.
